// File: rtl/mult_seq_ctrl.sv
// Sequencer and accumulator for a repeated-addition multiplier driving an external
// loadable down-counter. It cross-checks the counter against an internal shadow count.
module mult_seq_ctrl #(
  parameter int WIDTH = 16,
  parameter int PW    = 2 * WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] cnt_in,
  output logic             ld,
  output logic             dec,
  output logic [WIDTH-1:0] cnt_din,
  output logic [PW-1:0]    product,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_CHECK = 3'd2,
    S_ADD   = 3'd3,
    S_FIN   = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] iter_q, iter_d;
  logic [PW-1:0]    product_q, product_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] expected;

  // The counter should always read B minus the number of decrements issued.
  assign expected = b_q - iter_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      iter_q    <= '0;
      product_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      iter_q    <= iter_d;
      product_q <= product_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    iter_d    = iter_q;
    product_d = product_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d       = a_in;
          b_d       = b_in;
          iter_d    = '0;
          product_d = '0;
          err_d     = 1'b0;
          state_d   = S_LOAD;
        end
      end
      S_LOAD:  state_d = S_CHECK;
      S_CHECK: begin
        if (cnt_in != expected) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end else if (cnt_in == '0) begin
          state_d = S_FIN;
        end else begin
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        product_d = product_q + {{WIDTH{1'b0}}, a_q};
        iter_d    = iter_q + {{(WIDTH-1){1'b0}}, 1'b1};
        state_d   = S_CHECK;
      end
      S_FIN:   state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ld      = (state_q == S_LOAD);
    dec     = (state_q == S_ADD);
    done    = (state_q == S_FIN) || (state_q == S_ERR);
    busy    = (state_q != S_IDLE);
    cnt_din = b_q;
    product = product_q;
    err     = err_q;
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Directed bench for mult_seq_ctrl with a behavioural down-counter model in the loop.
// A second, 8-bit instance covers the all-ones operand corner in a short run.
module tb_mult_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] a_in = '0, b_in = '0, cnt_in, cnt_din;
  logic        ld, dec, busy, done, err;
  logic [31:0] product;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0, cnt8_in, cnt_din8;
  logic        ld8, dec8, busy8, done8, err8;
  logic [15:0] product8;

  logic [15:0] cnt_q = '0;
  logic [7:0]  cnt8_q = '0;
  logic        stuck = 1'b0;

  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Counter models: load on ld, decrement on dec (unless forced stuck); not reset.
  always @(posedge clk) begin
    if (ld) cnt_q <= cnt_din;
    else if (dec && !stuck) cnt_q <= cnt_q - 16'd1;
    if (ld8) cnt8_q <= cnt_din8;
    else if (dec8) cnt8_q <= cnt8_q - 8'd1;
  end
  assign cnt_in  = cnt_q;
  assign cnt8_in = cnt8_q;

  mult_seq_ctrl #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
    .cnt_in(cnt_in), .ld(ld), .dec(dec), .cnt_din(cnt_din), .product(product),
    .busy(busy), .done(done), .err(err)
  );

  mult_seq_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a_in(a8), .b_in(b8),
    .cnt_in(cnt8_in), .ld(ld8), .dec(dec8), .cnt_din(cnt_din8), .product(product8),
    .busy(busy8), .done(done8), .err(err8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation; cyc is the cycle index (LOAD = 1) at which done is seen.
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input bit pulse_busy,
                        output int cyc, output int nld, output int ndec, output bit overlap);
    a_in = a; b_in = b; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1; nld = 0; ndec = 0; overlap = 1'b0;
    while (!done && cyc < 5000) begin
      nld += int'(ld);
      ndec += int'(dec);
      if (ld && dec) overlap = 1'b1;
      if (pulse_busy && (cyc % 64 == 5)) begin
        start = 1'b1; a_in = ~a; b_in = 16'h0003;
      end else begin
        start = 1'b0;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, ld, dec, done, err} !== 5'b0) begin
      fails++; $display("FAIL reset_flags: got %b expected 00000", {busy, ld, dec, done, err});
    end
    checks++;
    if (product !== 32'h0) begin
      fails++; $display("FAIL reset_product: got %h expected 00000000", product);
    end
    checks++;
    if (cnt_din !== 16'h0) begin
      fails++; $display("FAIL reset_cnt_din: got %h expected 0000", cnt_din);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int cyc, nld, ndec; bit ov;
    run_op(16'd7, 16'd3, 1'b0, cyc, nld, ndec, ov);
    checks++;
    if (cyc !== 9) begin fails++; $display("FAIL basic_latency: got %0d expected 9", cyc); end
    checks++;
    if (nld !== 1) begin fails++; $display("FAIL basic_ld_count: got %0d expected 1", nld); end
    checks++;
    if (ndec !== 3) begin fails++; $display("FAIL basic_dec_count: got %0d expected 3", ndec); end
    checks++;
    if (product !== 32'd21) begin fails++; $display("FAIL basic_product: got %0d expected 21", product); end
    checks++;
    if (err !== 1'b0) begin fails++; $display("FAIL basic_err: got %b expected 0", err); end
    checks++;
    if (ov !== 1'b0) begin fails++; $display("FAIL basic_ld_dec_overlap: got %b expected 0", ov); end
    tick();
    checks++;
    if ({busy, done, product} !== {1'b0, 1'b0, 32'd21}) begin
      fails++; $display("FAIL basic_hold: got busy=%b done=%b product=%0d expected 0 0 21", busy, done, product);
    end
    $display("test_basic 7*3 cycles=%0d product=%0d", cyc, product);
  endtask

  task automatic test_b_zero();
    int cyc, nld, ndec; bit ov;
    run_op(16'h1234, 16'd0, 1'b0, cyc, nld, ndec, ov);
    checks++;
    if (cyc !== 3) begin fails++; $display("FAIL bzero_latency: got %0d expected 3", cyc); end
    checks++;
    if (ndec !== 0) begin fails++; $display("FAIL bzero_dec_count: got %0d expected 0", ndec); end
    checks++;
    if ({err, product} !== 33'h0) begin
      fails++; $display("FAIL bzero_result: got err=%b product=%h expected 0 00000000", err, product);
    end
    tick();
    $display("test_b_zero cycles=%0d product=%0d", cyc, product);
  endtask

  task automatic test_a_zero();
    int cyc, nld, ndec; bit ov;
    run_op(16'd0, 16'd5, 1'b0, cyc, nld, ndec, ov);
    checks++;
    if (ndec !== 5) begin fails++; $display("FAIL azero_dec_count: got %0d expected 5", ndec); end
    checks++;
    if ({err, product} !== 33'h0 || cyc !== 13) begin
      fails++; $display("FAIL azero_result: got err=%b product=%h cycles=%0d expected 0 00000000 13", err, product, cyc);
    end
    tick();
    $display("test_a_zero cycles=%0d product=%0d", cyc, product);
  endtask

  task automatic test_busy_start();
    int cyc, nld, ndec; bit ov;
    run_op(16'hFFFF, 16'h0100, 1'b1, cyc, nld, ndec, ov);
    checks++;
    if (product !== 32'h00FF_FF00) begin
      fails++; $display("FAIL busy_start_product: got %h expected 00ffff00", product);
    end
    checks++;
    if (cyc !== 515 || nld !== 1 || ov !== 1'b0) begin
      fails++; $display("FAIL busy_start_timing: got cycles=%0d ld=%0d overlap=%b expected 515 1 0", cyc, nld, ov);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin fails++; $display("FAIL busy_start_no_queue: got busy=%b expected 0", busy); end
    $display("test_busy_start cycles=%0d product=%h", cyc, product);
  endtask

  task automatic test_full_scale();
    int cyc;
    a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    cyc = 1;
    while (!done8 && cyc < 2000) begin tick(); cyc++; end
    checks++;
    if (cyc !== 513) begin fails++; $display("FAIL full_scale_latency: got %0d expected 513", cyc); end
    checks++;
    if ({err8, product8} !== {1'b0, 16'hFE01}) begin
      fails++; $display("FAIL full_scale_product: got err=%b product=%h expected 0 fe01", err8, product8);
    end
    tick();
    $display("test_full_scale 8-bit ff*ff cycles=%0d product=%h", cyc, product8);
  endtask

  task automatic test_stuck();
    int cyc, nld, ndec; bit ov;
    stuck = 1'b1;
    run_op(16'd3, 16'd2, 1'b0, cyc, nld, ndec, ov);
    checks++;
    if (cyc !== 5 || ndec !== 1) begin
      fails++; $display("FAIL stuck_timing: got cycles=%0d dec=%0d expected 5 1", cyc, ndec);
    end
    checks++;
    if ({done, err, product} !== {1'b1, 1'b1, 32'd3}) begin
      fails++; $display("FAIL stuck_result: got done=%b err=%b product=%0d expected 1 1 3", done, err, product);
    end
    tick();
    checks++;
    if ({busy, done, err, product} !== {1'b0, 1'b0, 1'b1, 32'd3}) begin
      fails++; $display("FAIL stuck_hold: got busy=%b done=%b err=%b product=%0d expected 0 0 1 3", busy, done, err, product);
    end
    stuck = 1'b0;
    $display("test_stuck cycles=%0d err=%b product=%0d", cyc, err, product);
  endtask

  task automatic test_reset_mid_add();
    int cyc, nld, ndec; bit ov;
    a_in = 16'd5; b_in = 16'd4; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    checks++;
    if ({dec, product} !== {1'b1, 32'd5}) begin
      fails++; $display("FAIL midadd_state: got dec=%b product=%0d expected 1 5", dec, product);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, ld, dec, done, err, product, cnt_din} !== 53'h0) begin
      fails++; $display("FAIL midadd_async_reset: got busy=%b ld=%b dec=%b done=%b err=%b product=%h cnt_din=%h expected all 0",
                        busy, ld, dec, done, err, product, cnt_din);
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    run_op(16'd2, 16'd2, 1'b0, cyc, nld, ndec, ov);
    checks++;
    if ({err, product} !== {1'b0, 32'd4} || cyc !== 7) begin
      fails++; $display("FAIL midadd_recover: got err=%b product=%0d cycles=%0d expected 0 4 7", err, product, cyc);
    end
    tick();
    $display("test_reset_mid_add recover product=%0d", product);
  endtask

  task automatic test_back_to_back();
    int k;
    a_in = 16'd1; b_in = 16'd1; start = 1'b1;
    tick();
    a_in = 16'd2; b_in = 16'd2;
    k = 1;
    while (!done && k < 50) begin tick(); k++; end
    checks++;
    if (k !== 5 || product !== 32'd1) begin
      fails++; $display("FAIL b2b_first: got cycles=%0d product=%0d expected 5 1", k, product);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin fails++; $display("FAIL b2b_idle_gap: got busy=%b expected 0", busy); end
    tick();
    checks++;
    if (ld !== 1'b1) begin fails++; $display("FAIL b2b_second_accept: got ld=%b expected 1", ld); end
    start = 1'b0;
    k = 1;
    while (!done && k < 50) begin tick(); k++; end
    checks++;
    if (k !== 7 || product !== 32'd4 || err !== 1'b0) begin
      fails++; $display("FAIL b2b_second: got cycles=%0d product=%0d err=%b expected 7 4 0", k, product, err);
    end
    tick();
    $display("test_back_to_back second product=%0d", product);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_b_zero();
    test_a_zero();
    test_busy_start();
    test_full_scale();
    test_stuck();
    test_reset_mid_add();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
